// File: rtl/quad_hall_pkg.sv
// Shared types and helpers for the quadrature hall-signal generator.
// CNT_W is shared with the angle tracking unit so both agree on position width.
package quad_hall_pkg;

  localparam int unsigned CNT_W = 12;

  // Values are listed in clockwise order so that +1 / -1 walks the sequence.
  typedef enum logic [1:0] {
    PH_00 = 2'd0,
    PH_01 = 2'd1,
    PH_11 = 2'd2,
    PH_10 = 2'd3
  } phase_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_t;

  // Returns {hall_1, hall_2} for a phase.
  function automatic logic [1:0] phase_to_hall(input phase_t ph);
    logic [1:0] hall;
    hall = 2'b00;
    unique case (ph)
      PH_00:   hall = 2'b00;
      PH_01:   hall = 2'b01;
      PH_11:   hall = 2'b11;
      PH_10:   hall = 2'b10;
      default: hall = 2'b00;
    endcase
    return hall;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Dwell timer: loads on start and emits a one-cycle tick every PHASE_TICKS
// cycles while enabled.
module phase_timer #(
  parameter int unsigned PHASE_TICKS = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = $clog2(PHASE_TICKS);
  localparam logic [CntW-1:0] Reload = CntW'(PHASE_TICKS - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = Reload;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? Reload : cnt_q - CntW'(1);
    end
  end

  assign tick = en && !start && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quad_hall_generator.sv
// Quadrature hall-signal transmitter: emits N full hall_1/hall_2 cycles per
// accepted command and keeps a running step position.
module quad_hall_generator #(
  parameter int unsigned PHASE_TICKS = 50,
  parameter int unsigned CNT_W       = quad_hall_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_clockwise,
  input  logic [CNT_W-1:0] cmd_steps,
  output logic             hall_1,
  output logic             hall_2,
  output logic [CNT_W-1:0] position,
  output logic             busy,
  output logic             done
);

  import quad_hall_pkg::*;

  gen_state_t       state_d, state_q;
  phase_t           phase_d, phase_q;
  logic [1:0]       hall_d, hall_q;
  logic [CNT_W-1:0] steps_d, steps_q;
  logic [CNT_W-1:0] pos_d, pos_q;
  logic             cw_d, cw_q;
  logic             done_d, done_q;
  logic             accept;
  logic             timer_start;
  logic             timer_en;
  logic             tick;

  assign accept   = cmd_valid && (state_q == IDLE);
  // Timer stops once the final transition has been made.
  assign timer_en = (state_q == RUN) && !done_q;

  phase_timer #(
    .PHASE_TICKS(PHASE_TICKS)
  ) u_phase_timer (
    .clk  (clk),
    .reset(reset),
    .start(timer_start),
    .en   (timer_en),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hall_d      = hall_q;
    steps_d     = steps_q;
    pos_d       = pos_q;
    cw_d        = cw_q;
    done_d      = 1'b0;
    timer_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cw_d    = cmd_clockwise;
          steps_d = cmd_steps;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = RUN;
            timer_start = 1'b1;
          end
        end
      end
      RUN: begin
        // done_q marks the completion cycle; busy is released after it.
        if (done_q) begin
          state_d = IDLE;
        end else if (tick) begin
          phase_d = cw_q ? phase_t'(phase_q + 2'd1) : phase_t'(phase_q - 2'd1);
          hall_d  = phase_to_hall(phase_d);
          // Counting edges: hall_1 rise (01->11) cw, hall_2 rise (10->11) acw.
          if (cw_q && (phase_q == PH_01)) begin
            pos_d = pos_q + CNT_W'(1);
          end
          if (!cw_q && (phase_q == PH_10)) begin
            pos_d = pos_q - CNT_W'(1);
          end
          if (phase_d == PH_00) begin
            steps_d = steps_q - CNT_W'(1);
            if (steps_q == CNT_W'(1)) begin
              done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= PH_00;
      hall_q  <= 2'b00;
      steps_q <= '0;
      pos_q   <= '0;
      cw_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hall_q  <= hall_d;
      steps_q <= steps_d;
      pos_q   <= pos_d;
      cw_q    <= cw_d;
      done_q  <= done_d;
    end
  end

  assign hall_1    = hall_q[1];
  assign hall_2    = hall_q[0];
  assign position  = pos_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);
  assign cmd_ready = (state_q == IDLE);

endmodule

// File: doc/quad_hall_generator.md
Name: quad_hall_generator

Overview:
Quadrature hall-signal transmitter that produces hall_1/hall_2 waveforms for the angle tracking unit. Takes a handshaked step command (direction, step count) and emits the matching quadrature sequence at a fixed phase dwell. It also keeps a running 12-bit position of emitted steps. Used as a shaft-sensor emulator for bench loopback and motor-model bring-up, feeding the tracker's hall inputs directly.

Parameters:
PHASE_TICKS, 50, clock cycles each quadrature phase is held (must be >= 2)
CNT_W, 12, width of step count and position (matches tracker angle width)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  generator idle and able to accept a command
cmd_clockwise  input  1  1 = clockwise, 0 = anticlockwise; sampled on accept
cmd_steps  input  CNT_W  number of full quadrature cycles to emit; sampled on accept
hall_1  output  1  quadrature channel 1, registered
hall_2  output  1  quadrature channel 2, registered
position  output  CNT_W  running step count, modulo 2^CNT_W
busy  output  1  high from accept until completion
done  output  1  one-cycle pulse on command completion

Behaviour:
- Reset (reset=0, async): hall_1=0, hall_2=0, position=0, busy=0, done=0, cmd_ready=1, state IDLE, phase 0, dwell counter cleared. Any command in progress is dropped; no done pulse.
- Accept: cmd_valid && cmd_ready on a rising edge latches direction and steps. cmd_ready is high only in IDLE.
- States: IDLE -> RUN on accept with steps != 0. IDLE -> IDLE on accept with steps == 0; done pulses in the next cycle, busy stays 0, and the outputs do not change. RUN -> IDLE after the final transition back to phase 0.
- Phase encoding (hall_1,hall_2):
  - Phase 0 = 00, 1 = 01, 2 = 11, 3 = 10.
  - Clockwise advances the phase 0->1->2->3->0. hall_1 rises while hall_2=1.
  - Anticlockwise visits phases 0->3->2->1->0 (00->10->11->01->00). hall_2 rises while hall_1=1.
- Dwell: the current phase is held for PHASE_TICKS cycles. The first transition occurs PHASE_TICKS cycles after the accept edge. Every later transition occurs PHASE_TICKS cycles after the previous one.
- One step = 4 transitions, ending back at 00. A command of N steps takes 4*N*PHASE_TICKS cycles from accept to the final transition.
- position update:
  - Updated in the same cycle as the counting edge: the hall_1 rise when clockwise (+1), the hall_2 rise when anticlockwise (-1).
  - Wraps modulo 2^CNT_W: 4095+1 -> 0 and 0-1 -> 4095.
  - Retained across commands; cleared only by reset.
- Completion: on the cycle of the final transition to 00, done=1 for exactly one cycle. busy drops and cmd_ready rises in the following cycle.
- busy=1 from the cycle after accept through the completion cycle.
- cmd_valid while busy is ignored and is not queued. Command inputs are don't-care except on the accept edge.
- Outputs never glitch: at most one of hall_1/hall_2 changes per transition, and both are driven straight from flops.

Decomposition:
- Shared package quad_hall_pkg:
  - typedef phase_t, 2-bit, with PH_00, PH_01, PH_11, PH_10.
  - typedef gen_state_t with IDLE and RUN.
  - Function phase_to_hall(phase_t) returning {hall_1,hall_2}.
  - Constant CNT_W = 12, shared with angle_tracking_unit.
- One sub-module, phase_timer:
  - Parameterised down-counter on PHASE_TICKS.
  - Loads on start, emits a one-cycle tick every PHASE_TICKS cycles while enabled.
  - Same clk/reset.
- Top module holds the FSM, phase register, step counter and position.

Test Plan:
- PHASE_TICKS=4, reset, then accept cw steps=3 -> sequence 00,01,11,10 repeated 3 times, each phase held 4 cycles. position=1,2,3 at each hall_1 rise. done pulses at cycle 48 after accept; cmd_ready=1 at cycle 49.
- position=0, accept acw steps=1 -> sequence 00,10,11,01,00. position goes to 4095 on the hall_2 rise. done pulses once.
- Accept cw steps=5, hold cmd_valid=1 with acw steps=7 throughout -> cmd_ready=0 while busy, second command not taken until after done, then accepted the cycle cmd_ready=1.
- Accept steps=0 -> done pulses the next cycle, busy never asserts, hall outputs stay 00, position unchanged.
- Assert reset=0 asynchronously mid-phase during a cw steps=10 run -> hall_1=hall_2=0, position=0, busy=0, no done, cmd_ready=1 immediately (before the next clk edge).
- Loopback into angle_tracking_unit with cw steps=20 then acw steps=5 -> tracker and generator position agree at 20 then 15. Monitor assertion: no cycle where both halls change.
